// File: rtl/seq_pkg.sv
// Shared definitions for the round-robin serial pattern detector.
package seq_pkg;

   // Default configuration of the detector.
   localparam int               DEF_PLEN    = 4;
   localparam logic [3:0]       DEF_PATTERN = 4'b1001;
   localparam int               DEF_CW      = 8;

   // Width of an index able to address n items (at least one bit).
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Per-channel detector context in the default configuration:
   // bit history (newest bit in the LSB), fill level, match count.
   typedef struct packed {
      logic [DEF_PLEN-2:0]            hist;
      logic [idx_width(DEF_PLEN)-1:0] fill;
      logic [DEF_CW-1:0]              cnt;
   } seq_ctx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at ptr and the first
// requesting channel wins. The pointer itself is kept by the parent.
module rr_arbiter
   import seq_pkg::*;
#(
   parameter  int NCH = 4,
   localparam int IW  = idx_width(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [IW-1:0]  idx,
   output logic           any
);

   logic [IW-1:0] cand;

   // Scan channels ptr, ptr+1, ... (wrapping) and grant the first requester.
   always_comb begin
      // NOTE: combinational logic uses blocking assignments with every output
      // given a default first, so no path leaves a value held (no latch).
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = IW'((int'(ptr) + k) % NCH);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/seq_detect_sched.sv
// Shares one serial pattern-detector engine among NCH bit-serial channels.
// One channel is granted per cycle in round-robin order; its saved context
// (history, fill, match count) is advanced and matches are reported with
// the channel id one cycle later.
module seq_detect_sched
   import seq_pkg::*;
#(
   parameter  int              NCH         = 4,
   parameter  int              PLEN        = DEF_PLEN,
   parameter  logic [PLEN-1:0] PATTERN_RST = PLEN'(DEF_PATTERN),
   parameter  int              CW          = DEF_CW,
   localparam int              IW          = idx_width(NCH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_we,
   input  logic [PLEN-1:0] cfg_pattern,
   input  logic [NCH-1:0]  ch_en,
   input  logic [NCH-1:0]  bit_valid,
   input  logic [NCH-1:0]  bit_in,
   output logic [NCH-1:0]  bit_ready,
   output logic            match_valid,
   output logic [IW-1:0]   match_ch,
   output logic [CW-1:0]   match_count,
   output logic [IW-1:0]   grant_ch
);

   localparam int            FW        = idx_width(PLEN);
   localparam logic [FW-1:0] FILL_FULL = FW'(PLEN - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   // Context record sized for this instance's PLEN and CW.
   typedef struct packed {
      logic [PLEN-2:0] hist;
      logic [FW-1:0]   fill;
      logic [CW-1:0]   cnt;
   } ctx_t;

   ctx_t            ctx [NCH];
   logic [PLEN-1:0] pattern;
   logic [IW-1:0]   ptr;

   logic [NCH-1:0]  req;
   logic [NCH-1:0]  gnt;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;

   ctx_t            cur;
   logic            cur_bit;
   logic [PLEN-1:0] cand;
   logic            hit;
   logic [FW-1:0]   fill_next;
   logic [CW-1:0]   cnt_next;

   // Configuration writes and reset block every transfer.
   assign req       = bit_valid & ch_en & {NCH{~cfg_we & reset}};
   assign bit_ready = gnt;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // Shared engine: evaluate the granted channel's context against the pattern.
   always_comb begin
      cur       = ctx[gnt_idx];
      cur_bit   = bit_in[gnt_idx];
      cand      = {cur.hist, cur_bit};
      hit       = gnt_any && (cur.fill == FILL_FULL) && (cand == pattern);
      fill_next = (cur.fill == FILL_FULL) ? cur.fill : cur.fill + 1'b1;
      cnt_next  = (cur.cnt == CNT_MAX) ? cur.cnt : cur.cnt + 1'b1;
   end

   // Per-channel contexts: cleared by reset/config, history dropped while
   // disabled, granted channel advanced.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: contexts live in flops with a reset, not a RAM, because every
      // channel must clear in the same cycle; state updates use <= only.
      if (!reset) begin
         for (int i = 0; i < NCH; i++) ctx[i] <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < NCH; i++) ctx[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i]) begin
               ctx[i].hist <= '0;
               ctx[i].fill <= '0;
            end
         end
         if (gnt_any) begin
            ctx[gnt_idx].hist <= cand[PLEN-2:0];
            ctx[gnt_idx].fill <= fill_next;
            if (hit) ctx[gnt_idx].cnt <= cnt_next;
         end
      end
   end

   // Active pattern register, reloaded by a configuration write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      pattern <= PATTERN_RST;
      else if (cfg_we) pattern <= cfg_pattern;
   end

   // Round-robin pointer moves past the granted channel; debug grant id.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         grant_ch <= '0;
      end else if (gnt_any) begin
         ptr      <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
         grant_ch <= gnt_idx;
      end
   end

   // Registered match report; id and count hold between matches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         match_valid <= 1'b0;
         match_ch    <= '0;
         match_count <= '0;
      end else begin
         match_valid <= hit;
         if (hit) begin
            match_ch    <= gnt_idx;
            match_count <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: a reference model predicts grants
// and match reports; a second instance with a 2-bit counter shows saturation.
module tb_seq_detect_sched;

   localparam int NCH  = 4;
   localparam int PLEN = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [3:0] cfg_pattern;
   logic [3:0] ch_en, bit_valid, bit_in;

   logic [3:0] bit_ready,   bit_ready2;
   logic       match_valid, match_valid2;
   logic [1:0] match_ch,    match_ch2;
   logic [7:0] match_count;
   logic [1:0] match_count2;
   logic [1:0] grant_ch,    grant_ch2;

   always #5 clk = ~clk;

   seq_detect_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN_RST(4'b1001), .CW(8)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .ch_en(ch_en), .bit_valid(bit_valid), .bit_in(bit_in),
      .bit_ready(bit_ready), .match_valid(match_valid), .match_ch(match_ch),
      .match_count(match_count), .grant_ch(grant_ch)
   );

   seq_detect_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN_RST(4'b1001), .CW(2)) dut_cw2 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .ch_en(ch_en), .bit_valid(bit_valid), .bit_in(bit_in),
      .bit_ready(bit_ready2), .match_valid(match_valid2), .match_ch(match_ch2),
      .match_count(match_count2), .grant_ch(grant_ch2)
   );

   typedef struct {
      logic valid;
      int   ch;
      int   cnt8;
      int   cnt2;
      int   gch;
   } exp_t;

   exp_t sb[$];
   bit   bit_q[NCH][$];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int         m_ptr;
   logic [2:0] m_hist [NCH];
   int         m_fill [NCH];
   int         m_c8   [NCH];
   int         m_c2   [NCH];
   logic [3:0] m_pat;
   int         last_ch, last8, last2, last_g;
   int         m_grant;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_pat = 4'b1001;
      for (int i = 0; i < NCH; i++) begin
         m_hist[i] = '0; m_fill[i] = 0; m_c8[i] = 0; m_c2[i] = 0;
      end
      last_ch = 0; last8 = 0; last2 = 0; last_g = 0;
      m_grant = -1;
      sb.delete();
   endtask

   task automatic check_outputs(input exp_t o);
      check("match_valid",     {31'd0, match_valid},  {31'd0, o.valid});
      check("match_ch",        {30'd0, match_ch},     o.ch);
      check("match_count",     {24'd0, match_count},  o.cnt8);
      check("grant_ch",        {30'd0, grant_ch},     o.gch);
      check("match_valid_cw2", {31'd0, match_valid2}, {31'd0, o.valid});
      check("match_count_cw2", {30'd0, match_count2}, o.cnt2);
   endtask

   // One clock cycle: check last cycle's outputs, predict this cycle.
   task automatic step();
      exp_t       e;
      logic [3:0] er;
      logic [3:0] cand;
      logic       hit;
      int         g;
      @(negedge clk);
      if (sb.size() > 0) check_outputs(sb.pop_front());
      er  = '0;
      g   = -1;
      hit = 1'b0;
      if (cfg_we) begin
         m_pat = cfg_pattern;
         for (int i = 0; i < NCH; i++) begin
            m_hist[i] = '0; m_fill[i] = 0; m_c8[i] = 0; m_c2[i] = 0;
         end
      end else begin
         for (int i = 0; i < NCH; i++)
            if (!ch_en[i]) begin m_hist[i] = '0; m_fill[i] = 0; end
         for (int k = 0; k < NCH; k++)
            if (g < 0 && bit_valid[(m_ptr + k) % NCH] && ch_en[(m_ptr + k) % NCH])
               g = (m_ptr + k) % NCH;
         if (g >= 0) begin
            er[g] = 1'b1;
            cand  = {m_hist[g], bit_in[g]};
            hit   = (m_fill[g] == PLEN - 1) && (cand == m_pat);
            m_hist[g] = cand[2:0];
            if (m_fill[g] < PLEN - 1) m_fill[g]++;
            if (hit) begin
               if (m_c8[g] < 255) m_c8[g]++;
               if (m_c2[g] < 3)   m_c2[g]++;
               last_ch = g; last8 = m_c8[g]; last2 = m_c2[g];
            end
            m_ptr  = (g + 1) % NCH;
            last_g = g;
         end
      end
      e.valid = hit; e.ch = last_ch; e.cnt8 = last8; e.cnt2 = last2; e.gch = last_g;
      sb.push_back(e);
      check("bit_ready",     {28'd0, bit_ready},  {28'd0, er});
      check("bit_ready_cw2", {28'd0, bit_ready2}, {28'd0, er});
      m_grant = g;
      @(posedge clk);
      #1;
   endtask

   task automatic push_bits(input int ch, input string s);
      for (int i = 0; i < s.len(); i++) bit_q[ch].push_back(s[i] == 8'h31);
   endtask

   // Offer queued bits on every channel until all are consumed (bounded).
   task automatic run(input logic [3:0] en, input int max_cycles);
      int cycles = 0;
      int left;
      ch_en  = en;
      cfg_we = 1'b0;
      forever begin
         left = 0;
         for (int i = 0; i < NCH; i++) left += bit_q[i].size();
         if (left == 0 || cycles >= max_cycles) break;
         for (int i = 0; i < NCH; i++) begin
            bit_valid[i] = (bit_q[i].size() > 0);
            bit_in[i]    = (bit_q[i].size() > 0) ? bit_q[i][0] : 1'b0;
         end
         step();
         if (m_grant >= 0 && bit_q[m_grant].size() > 0) void'(bit_q[m_grant].pop_front());
         cycles++;
      end
      if (left != 0) begin
         check("stream_timeout", left, 0);
         for (int i = 0; i < NCH; i++) bit_q[i].delete();
      end
      bit_valid = '0;
      bit_in    = '0;
   endtask

   task automatic idle(input int n);
      bit_valid = '0;
      cfg_we    = 1'b0;
      repeat (n) step();
   endtask

   task automatic cfg_step(input logic [3:0] pat, input logic [3:0] valid, input logic [3:0] bits);
      cfg_we      = 1'b1;
      cfg_pattern = pat;
      bit_valid   = valid;
      bit_in      = bits;
      step();
      cfg_we    = 1'b0;
      bit_valid = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      ch_en       = '1;
      bit_valid   = '1;
      bit_in      = '1;
      model_reset();

      // reset state with every channel requesting
      #12;
      check("rst_bit_ready",   {28'd0, bit_ready},   0);
      check("rst_match_valid", {31'd0, match_valid}, 0);
      check("rst_match_ch",    {30'd0, match_ch},    0);
      check("rst_match_count", {24'd0, match_count}, 0);
      check("rst_grant_ch",    {30'd0, grant_ch},    0);
      @(negedge clk);
      bit_valid = '0;
      bit_in    = '0;
      reset     = 1'b1;
      @(posedge clk);
      #1;

      // single channel, single match
      push_bits(0, "1001");
      run(4'hF, 20);
      idle(2);

      // overlapping matches on ch1
      push_bits(1, "1001001");
      run(4'hF, 20);
      idle(2);

      // two channels sharing the engine, starting from ptr=0
      pulse_reset();
      push_bits(0, "1001");
      push_bits(2, "1001");
      run(4'hF, 20);
      idle(2);

      // config write mid-stream: no transfer, contexts cleared, new pattern
      push_bits(0, "100");
      run(4'hF, 20);
      cfg_step(4'b1101, 4'b0001, 4'b0001);
      push_bits(0, "11101");
      run(4'hF, 20);
      idle(2);

      // channel disable drops history but keeps the count
      cfg_step(4'b1001, 4'b0000, 4'b0000);
      push_bits(3, "100100");
      run(4'hF, 20);
      ch_en     = 4'b0111;
      bit_valid = 4'b1000;
      bit_in    = 4'b1000;
      step();
      bit_valid = '0;
      push_bits(3, "1");
      run(4'hF, 20);
      push_bits(3, "001");
      run(4'hF, 20);
      idle(2);

      // counter saturation (CW=2 instance) then async reset during a pulse
      cfg_step(4'b1001, 4'b0000, 4'b0000);
      push_bits(0, "1001001001001001");
      run(4'hF, 40);
      check_outputs(sb.pop_front());
      ch_en     = '1;
      bit_valid = '1;
      #2;
      reset = 1'b0;
      #1;
      check("arst_bit_ready",       {28'd0, bit_ready},    0);
      check("arst_match_valid",     {31'd0, match_valid},  0);
      check("arst_match_ch",        {30'd0, match_ch},     0);
      check("arst_match_count",     {24'd0, match_count},  0);
      check("arst_grant_ch",        {30'd0, grant_ch},     0);
      check("arst_match_valid_cw2", {31'd0, match_valid2}, 0);
      check("arst_match_count_cw2", {30'd0, match_count2}, 0);
      model_reset();
      @(negedge clk);
      bit_valid = '0;
      reset     = 1'b1;
      @(posedge clk);
      #1;

      // after reset the default pattern is active again
      push_bits(2, "1001");
      run(4'hF, 20);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares one programmable serial-pattern detector engine among NCH independent bit-serial channels. Each channel has its own valid/ready bit handshake and saved detector context (bit history, fill level, match count). The block grants at most one channel per cycle, advances that channel's context, and reports matches with the channel ID. It sits between the serial input front-ends and the event/status logic.

## Interface
- NCH, 4, number of requesting channels (≥2)
- PLEN, 4, pattern length in bits (2..8)
- PATTERN_RST, 4'b1001, pattern loaded at reset (MSB = oldest bit)
- CW, 8, per-channel match counter width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  load cfg_pattern and clear all channel contexts
- cfg_pattern  in  PLEN  new pattern
- ch_en  in  NCH  per-channel enable
- bit_valid  in  NCH  channel i offers bit_in[i]
- bit_in  in  NCH  serial bit per channel
- bit_ready  out  NCH  one-hot grant; transfer = bit_valid[i] & bit_ready[i]
- match_valid  out  1  one-cycle pulse, pattern matched
- match_ch  out  clog2(NCH)  channel that matched
- match_count  out  CW  that channel's count after increment
- grant_ch  out  clog2(NCH)  last granted channel (debug)

## Operation
- Request vector req = bit_valid & ch_en; bit_ready is combinational from req and the rr pointer. No ready is raised when cfg_we=1.
- Round-robin: search starts at ptr; the first requesting channel g is granted; ptr <= (g+1) mod NCH. ptr is unchanged when there is no grant.
- Context per channel: hist[PLEN-2:0], fill (saturating 0..PLEN-1), cnt[CW-1:0].
- On transfer from channel g with bit b: cand = {hist[g], b}. Match iff fill[g]==PLEN-1 and cand==pattern. Update hist[g] <= cand[PLEN-2:0] and fill[g] <= min(fill+1, PLEN-1).
- Overlapping matches are allowed; history is not cleared on a match.
- On a match, cnt[g] increments and saturates at 2^CW-1.
- cfg_we=1: pattern <= cfg_pattern; all hist, fill and cnt clear to 0; no transfer in that cycle.
- ch_en[i]=0: hist[i] and fill[i] clear every cycle; cnt[i] is held.
- Outputs are registered. On a match: match_valid=1, match_ch=g, match_count=new cnt[g]. Otherwise match_valid=0 and match_ch/match_count hold their previous values.

## Timing
- Reset (asynchronous, immediate): pattern=PATTERN_RST, ptr=0, all contexts 0, match_valid=0, match_ch=0, match_count=0, grant_ch=0. bit_ready=0 while reset=0.
- Latency: a transfer in cycle T produces match_valid in cycle T+1.
- Throughput: one bit per cycle total, shared across channels. With all channels requesting, each channel receives one grant every NCH cycles.
- Simultaneous cfg_we and bit_valid: cfg_we wins and no transfer occurs. A match_valid produced by the previous cycle's transfer still appears.
- Reset asserted mid-stream: all state is lost and all outputs clear immediately.

## Structure
- Shared package seq_pkg holds: PLEN and PATTERN_RST defaults, the channel-index width function, and the context record typedef (hist, fill, cnt).
- Sub-module rr_arbiter (parameter NCH): takes req and ptr, returns a one-hot grant and the granted index. It is purely combinational; ptr is kept in the parent.
- Context storage is a register array in the parent, not RAM, because channels are cleared in parallel.

## Test plan
- Reset release, ch0 only, sends 1,0,0,1 on consecutive cycles -> match_valid=1 exactly in the cycle after the 4th transfer, match_ch=0, match_count=1; no pulse earlier.
- ch1 sends 1,0,0,1,0,0,1 -> two pulses, after the 4th and 7th bits, with counts 1 then 2 (overlap).
- ch0 and ch2 valid continuously, each sending 1,0,0,1 -> bit_ready alternates ch0, ch2, ch0, ...; ch1/ch3 never granted; ch0 matches after its 4th bit (cycle 7), ch2 after its 4th bit (cycle 8).
- ch0 sends 1,0,0, then cfg_we with 4'b1101 -> bit_ready=0 that cycle; next bit 1 gives no match; then 1,1,0,1 -> match, count=1.
- ch3 disabled via ch_en mid-pattern after 1,0,0, re-enabled, sends 1 -> no match (history cleared); cnt[3] retained.
- CW=2, ch0 produces 5 matches -> match_count sequence 1,2,3,3,3. Async reset pulse while match_valid=1 -> all outputs 0 immediately.
